// File: rtl/haraka256_round_seq.sv
// haraka256_round_seq
//   Iterative Haraka-256 permutation core. One step per clock: four steps
//   per Haraka round drive a shared external AES round unit (lane0, lane1,
//   lane0, lane1), and the fifth step applies MIX2 to the two lanes. After
//   5*NROUNDS steps the lanes are XORed with the saved input (feed-forward).
//   The result is held until the consumer takes it.
//
// Ports
//   clk, rst             : clock; asynchronous active-high reset
//   in_valid/in_ready    : message handshake (in_ready high only in IDLE)
//   in_data[255:0]       : message, lane0 = [127:0], lane1 = [255:128]
//   out_valid/out_ready  : digest handshake (out_valid high only in DONE)
//   out_data[255:0]      : digest, same lane packing as in_data
//   aes_in[127:0]        : operand for the external AES round
//   rc_idx[5:0]          : round-constant index for the external AES round
//   aes_out[127:0]       : combinational AES round result for aes_in/rc_idx
//   busy                 : high while the permutation is running
module haraka256_round_seq #(
  parameter int NROUNDS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic [127:0] aes_in,
  output logic [5:0]   rc_idx,
  input  logic [127:0] aes_out,
  output logic         busy
);

  localparam int NSTEPS = 5 * NROUNDS;
  localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [STEP_W-1:0] step;     // overall step, 0..NSTEPS-1
  logic [2:0]        k_cnt;    // step within the current Haraka round, 0..4
  logic [5:0]        rc_base;  // 4 * current Haraka round
  logic [127:0]      lane0;
  logic [127:0]      lane1;
  logic [255:0]      ff_copy;  // feed-forward copy of the accepted message

  logic         is_mix;
  logic         last_step;
  logic [127:0] mix0;
  logic [127:0] mix1;

  assign is_mix    = (k_cnt == 3'd4);
  assign last_step = (step == LAST_STEP);

  // MIX2: interleave 32-bit words, lane0 words a0..a3, lane1 words b0..b3.
  assign mix0 = {lane1[63:32],  lane0[63:32],  lane1[31:0],  lane0[31:0]};
  assign mix1 = {lane1[127:96], lane0[127:96], lane1[95:64], lane0[95:64]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // AES operand/constant are combinational from registered state, so an
  // asynchronous reset drops them to zero without waiting for a clock.
  always_comb begin
    aes_in = '0;
    rc_idx = '0;
    if (state == RUN && !is_mix) begin
      aes_in = k_cnt[0] ? lane1 : lane0;
      rc_idx = rc_base + {3'b000, k_cnt};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Step register stage: control, lanes, feed-forward copy and digest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      k_cnt    <= '0;
      rc_base  <= '0;
      lane0    <= '0;
      lane1    <= '0;
      ff_copy  <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            lane0   <= in_data[127:0];
            lane1   <= in_data[255:128];
            ff_copy <= in_data;
            step    <= '0;
            k_cnt   <= '0;
            rc_base <= '0;
          end
        end
        RUN: begin
          if (is_mix) begin
            lane0   <= mix0;
            lane1   <= mix1;
            k_cnt   <= '0;
            rc_base <= rc_base + 6'd4;
            // The last step is always a MIX2, so the digest is taken from
            // the mixed lanes directly rather than one cycle later.
            if (last_step) out_data <= {mix1, mix0} ^ ff_copy;
          end else begin
            if (k_cnt[0]) lane1 <= aes_out;
            else          lane0 <= aes_out;
            k_cnt <= k_cnt + 3'd1;
          end
          // Saturate at the terminal step; leaving RUN is the only exit.
          if (!last_step) step <= step + STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_haraka256_round_seq.sv
// Testbench for haraka256_round_seq. A stub AES round is attached to the
// aes_in/rc_idx/aes_out port trio; a software model of the whole
// permutation computes the expected digest of every accepted message.
module tb_haraka256_round_seq;

  localparam int NR     = 5;
  localparam int NSTEPS = 5 * NR;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [127:0] aes_in;
  logic [5:0]   rc_idx;
  logic [127:0] aes_out;
  logic         busy;

  int stub_mode = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [255:0] exp_q[$];
  int           acc_q[$];

  haraka256_round_seq #(.NROUNDS(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .aes_in   (aes_in),
    .rc_idx   (rc_idx),
    .aes_out  (aes_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Mode 0: plain XOR stub. Mode 1: rotate/shift mix so lane mistakes and
  // ordering errors cannot cancel out.
  function automatic logic [127:0] stub(input logic [127:0] x, input logic [5:0] rc, input int md);
    if (md == 0) return x ^ {122'b0, rc};
    return {x[120:0], x[127:121]} ^ (x >> 3) ^ {122'b0, rc} ^ {64{rc[1:0]}};
  endfunction

  function automatic logic [255:0] model(input logic [255:0] m, input int md);
    logic [127:0] a, b, t;
    logic [5:0]   rc;
    a = m[127:0];
    b = m[255:128];
    for (int s = 0; s < NSTEPS; s++) begin
      if (s % 5 == 4) begin
        t = a;
        a = {b[63:32],  t[63:32],  b[31:0],  t[31:0]};
        b = {b[127:96], t[127:96], b[95:64], t[95:64]};
      end else begin
        rc = 6'(4 * (s / 5) + s % 5);
        if ((s % 5) % 2 == 0) a = stub(a, rc, md);
        else                  b = stub(b, rc, md);
      end
    end
    return {b, a} ^ m;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  always_comb aes_out = stub(aes_in, rc_idx, stub_mode);

  // Scoreboard producer: every accepting edge queues its expected digest.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(in_data, stub_mode));
      acc_q.push_back(cyc);
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, rc_idx, aes_in, out_data} !== {1'b1, 1'b0, 1'b0, 6'd0, 128'd0, 256'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b rc=%0d aes_in=%h out=%h want 1 0 0 0 0 0",
               in_ready, out_valid, busy, rc_idx, aes_in, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rc_sequence();
    logic [5:0]   er;
    logic [255:0] e;
    stub_mode = 0; out_ready = 1'b1; in_data = '0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < NSTEPS; s++) begin
      er = (s % 5 == 4) ? 6'd0 : 6'(4 * (s / 5) + s % 5);
      n_cmp++;
      if (rc_idx !== er || busy !== 1'b1 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rc_seq step %0d: got rc=%0d busy=%b vld=%b want rc=%0d busy=1 vld=0",
                 s, rc_idx, busy, out_valid, er);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL rc_latency: got out_valid=%b queued=%0d want 1 at accept+25", out_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (out_data !== e) begin
        n_bad++;
        $display("FAIL rc_digest: got %h want %h", out_data, e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rc_done_one_cycle: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_hold();
    logic [255:0] e, snap;
    int w;
    stub_mode = 1; out_ready = 1'b0; in_data = rnd256(); in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_data = rnd256();
      @(negedge clk);
    end
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 40 || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL hold_timeout: got out_valid=%b queued=%0d want digest", out_valid, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    snap = out_data;
    n_cmp++;
    if (out_data !== e) begin
      n_bad++;
      $display("FAIL hold_digest: got %h want %h", out_data, e);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable cycle %0d: got vld=%b rdy=%b busy=%b data=%h want 1 0 0 %h",
                 i, out_valid, in_ready, busy, out_data, snap);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] e;
    int got;
    stub_mode = 1; out_ready = 1'b1; acc_q.delete();
    got = 0;
    in_valid = 1'b1; in_data = rnd256();
    for (int c = 0; c < 150 && got < 3; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_cmp++;
        if (out_data !== e) begin
          n_bad++;
          $display("FAIL b2b_digest %0d: got %h want %h", got, out_data, e);
        end
        got++;
        if (got == 3) in_valid = 1'b0;
      end
      in_data = rnd256();
    end
    @(negedge clk);
    n_cmp++;
    if (got != 3 || acc_q.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d digests %0d accepts want 3 3", got, acc_q.size());
    end else begin
      n_cmp++;
      if (acc_q[1] - acc_q[0] != 27 || acc_q[2] - acc_q[1] != 27) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d %0d want 27 27", acc_q[1] - acc_q[0], acc_q[2] - acc_q[1]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_drain: got queued=%0d rdy=%b want 0 1", exp_q.size(), in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [255:0] e;
    int w;
    stub_mode = 1; out_ready = 1'b1; in_data = rnd256(); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, rc_idx, aes_in, out_data} !== {1'b1, 1'b0, 1'b0, 6'd0, 128'd0, 256'd0}) begin
      n_bad++;
      $display("FAIL midrun_reset_async: got rdy=%b vld=%b busy=%b rc=%0d aes_in=%h out=%h want 1 0 0 0 0 0",
               in_ready, out_valid, busy, rc_idx, aes_in, out_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; in_data = rnd256(); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w != 25) begin
      n_bad++;
      $display("FAIL midrun_latency: got %0d want 25", w);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (out_data !== e) begin
      n_bad++;
      $display("FAIL midrun_digest: got %h want %h", out_data, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_done();
    int w;
    stub_mode = 0; out_ready = 1'b0; in_data = rnd256(); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 40) begin
      n_bad++;
      $display("FAIL done_reset_reach: got out_valid=%b want 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 256'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL done_reset_async: got vld=%b rdy=%b out=%h want 0 1 0", out_valid, in_ready, out_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL done_reset_no_digest cycle %0d: got vld=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rc_sequence();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/haraka256_round_seq.md
HARAKA256_ROUND_SEQ -- requirements
Module: haraka256_round_seq

Interface
REQ-001 SHALL have parameter NROUNDS, default 5: Haraka rounds; each round is 2 AES rounds per lane followed by MIX2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: message available.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a message.
REQ-006 SHALL have port in_data, input, 256 bits: message; lane0 = [127:0], lane1 = [255:128].
REQ-007 SHALL have port out_valid, output, 1 bit: digest available.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the digest.
REQ-009 SHALL have port out_data, output, 256 bits: digest, same lane packing as in_data.
REQ-010 SHALL have port aes_in, output, 128 bits: operand to the shared external AES round (SubBytes, ShiftRow, MixColumns, AddRoundKey).
REQ-011 SHALL have port rc_idx, output, 6 bits: round-constant ROM index.
REQ-012 SHALL have port aes_out, input, 128 bits: combinational AES round result for aes_in and the constant at rc_idx, valid in the same cycle.
REQ-013 SHALL have port busy, output, 1 bit: high in the RUN state.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE with a step counter of 0..5*NROUNDS-1.
REQ-015 SHALL drive in_ready=1 only in IDLE; an in_valid&in_ready edge SHALL load lane0/lane1 state and a 256-bit feed-forward copy, clear the step counter, and enter RUN.
REQ-016 SHALL decode RUN step s as r=s/5 and k=s%5.
REQ-017 SHALL, for RUN steps k=0..3, select lane = k%2, drive aes_in = that lane, drive rc_idx = 4r+k, and write aes_out back to that lane at the edge.
REQ-018 SHALL, for RUN step k=4 (MIX2), perform no AES use; 32-bit word i of a lane = bits[32i+31:32i]; with lane0 words a0..a3 and lane1 words b0..b3, new lane0 = {b1,a1,b0,a0} and new lane1 = {b3,a3,b2,a2} (MSW first).
REQ-019 SHALL drive aes_in=0 and rc_idx=0 outside RUN and during MIX2 steps.
REQ-020 SHALL, on the edge completing step 5*NROUNDS-1, enter DONE with out_data = {lane1,lane0} XOR the feed-forward copy.
REQ-021 SHALL assert out_valid exactly 5*NROUNDS edges after the accepting edge (25 cycles at default).
REQ-022 SHALL hold out_valid and out_data stable in DONE until out_ready=1; that edge SHALL return to IDLE, so in_ready rises on the following cycle (no overlap of acceptance and delivery).
REQ-023 SHALL ignore in_valid outside IDLE and SHALL not capture or alter in_data then.
REQ-024 SHALL allow out_ready to be high before DONE, which SHALL have no effect; DONE with out_ready already high SHALL last exactly one cycle.
REQ-025 SHALL never let the step counter wrap; leaving RUN is the only exit from a terminal step.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-RUN or in DONE, immediately enter IDLE and force in_ready=1, out_valid=0, busy=0, out_data=0, aes_in=0, rc_idx=0, and clear the lane and copy registers; an aborted message is discarded.
REQ-027 SHALL accept a new message on the first edge after rst deasserts when in_valid=1.

Verification
REQ-028 SHALL be checked with a stub AES model (aes_out = aes_in XOR {122'b0, rc_idx}) and in_data=0: the rc_idx sequence is 0,1,2,3,-,4,...,19,-; out_valid occurs at accept+25; out_data matches the software model of REQ-017/018/020.
REQ-029 SHALL be checked with a real AES round, the Haraka RC ROM, and in_data bytes 0x00..0x1f (byte j at bits[8j+7:8j]): out_data bytes = 80 27 cc b8 79 49 77 4b 78 d0 54 5f b7 2b f7 0c 69 5c 2a 09 23 cb d4 7b ba 11 59 ef bf 2b 2c 1c (byte0 first).
REQ-030 SHALL be checked with out_ready held low for 10 cycles after DONE: out_valid and out_data stay constant, in_ready=0 and busy=0 throughout; the out_ready pulse leads to in_ready=1 on the next cycle.
REQ-031 SHALL be checked with in_valid held high continuously and in_data changing every cycle: only the values at the accepting edges are hashed; back-to-back acceptances are 27 cycles apart with out_ready tied high.
REQ-032 SHALL be checked with rst asserted for one cycle at step 12, followed by a new message: all outputs take their reset values asynchronously, and the second digest equals its standalone result.
REQ-033 SHALL be checked with rst asserted while in DONE: out_valid falls without a clock edge, and no digest is delivered.
